// File: rtl/pkt_byte_ctrl.sv
// Packet-framing controller: header byte + fixed payload, header filter,
// FIFO back-pressure with drop reporting and packet-type tag.
module pkt_byte_ctrl #(
   parameter int         PAYLOAD_BYTES = 4,
   parameter logic [7:0] HDR_A         = 8'hA5,
   parameter logic [7:0] HDR_B         = 8'hC3,
   parameter bit         FILTER_EN     = 1'b1,
   parameter int         CNT_W         = $clog2(PAYLOAD_BYTES + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             byte_valid,
   input  logic [7:0]       byte_in,
   input  logic             fifo_full,
   output logic             write,
   output logic [7:0]       wr_data,
   output logic             pkt_tag,
   output logic [CNT_W-1:0] byte_idx,
   output logic             pkt_done,
   output logic             pkt_drop,
   output logic [7:0]       drop_cnt
);

   localparam logic [1:0] HDR  = 2'd0;
   localparam logic [1:0] PASS = 2'd1;
   localparam logic [1:0] SKIP = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PAYLOAD_BYTES);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt;
   logic             is_last;
   logic             hit_a;
   logic             hit_b;

   assign nxt     = cnt + CNT_W'(1);
   assign is_last = (nxt == LAST);
   assign hit_a   = (byte_in == HDR_A);
   assign hit_b   = (byte_in == HDR_B);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= HDR;
         cnt      <= '0;
         write    <= 1'b0;
         wr_data  <= 8'h00;
         pkt_tag  <= 1'b0;
         byte_idx <= '0;
         pkt_done <= 1'b0;
         pkt_drop <= 1'b0;
         drop_cnt <= 8'h00;
      end else begin
         write    <= 1'b0;
         pkt_done <= 1'b0;
         pkt_drop <= 1'b0;
         case (state)
            HDR: begin
               if (byte_valid) begin
                  cnt <= '0;
                  if (hit_a || hit_b) begin
                     state   <= PASS;
                     pkt_tag <= hit_b;
                  end else if (FILTER_EN) begin
                     state <= SKIP;
                  end else begin
                     state   <= PASS;
                     pkt_tag <= 1'b0;
                  end
               end
            end
            PASS: begin
               if (byte_valid) begin
                  cnt <= nxt;
                  if (!fifo_full) begin
                     write    <= 1'b1;
                     wr_data  <= byte_in;
                     byte_idx <= nxt;
                     if (is_last) begin
                        pkt_done <= 1'b1;
                        state    <= HDR;
                     end
                  end else begin
                     pkt_drop <= 1'b1;
                     if (drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                     // a drop on the final byte leaves nothing to skip
                     state <= is_last ? HDR : SKIP;
                  end
               end
            end
            SKIP: begin
               if (byte_valid) begin
                  cnt <= nxt;
                  if (is_last)
                     state <= HDR;
               end
            end
            default: begin
               state <= HDR;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
